// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field
// positions and the write masks that define which bits software can change.
package cp0_pkg;

   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_PAGEMASK = 5'd5;
   localparam logic [4:0] CP0_WIRED    = 5'd6;
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_CONFIG   = 5'd16;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int ST_IE    = 0;
   localparam int ST_EXL   = 1;
   localparam int ST_UM    = 4;
   localparam int ST_IM_LO = 8;
   localparam int ST_BEV   = 22;

   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;
   localparam int CA_TI     = 30;
   localparam int CA_BD     = 31;

   localparam logic [31:0] STATUS_WMASK   = 32'h0040_FF13;
   localparam logic [31:0] STATUS_RESET   = 32'h0040_0000;
   localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
   localparam logic [31:0] ENTRYLO_WMASK  = 32'h03FF_FFFF;
   localparam logic [31:0] PAGEMASK_WMASK = 32'h01FF_E000;
   localparam logic [2:0]  K0_RESET       = 3'b011;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV clocks, and the
// sticky timer interrupt TI is raised the cycle after Count matches Compare.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

   logic [3:0]  presc_q, presc_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;

   always_comb begin
      presc_d   = presc_q;
      count_d   = count_q;
      compare_d = compare_q;
      if (count_we) begin
         count_d = wdata;
         presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         count_d = count_q + 32'd1;
      end else begin
         presc_d = presc_q + 4'd1;
      end
      if (compare_we) compare_d = wdata;
      // Writing Compare acknowledges the interrupt and beats a same-cycle match.
      ti_d = compare_we ? 1'b0 : (ti_q | (count_q == compare_q));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regs_p.sv
// MIPS-style coprocessor-0 register file: mtc0/mfc0 access, exception and eret
// bookkeeping, TLB support registers and interrupt pending generation.
module cp0_regs_p
   import cp0_pkg::*;
#(
   parameter int  TLB_ENTRIES = 16,
   parameter int  HW_INT      = 6,
   parameter int  COUNT_DIV   = 2,
   localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [31:0]       wdata,
   input  logic [4:0]        raddr,
   output logic [31:0]       rdata,
   input  logic              exc_valid,
   input  logic [4:0]        exc_code,
   input  logic [31:0]       exc_pc,
   input  logic              exc_bd,
   input  logic              exc_badva_we,
   input  logic [31:0]       exc_badva,
   input  logic              eret,
   input  logic [HW_INT-1:0] hw_int,
   input  logic              tlbp_we,
   input  logic              tlbp_hit,
   input  logic [IDX_W-1:0]  tlbp_idx,
   input  logic              tlbr_we,
   input  logic [31:0]       tlbr_hi,
   input  logic [31:0]       tlbr_lo0,
   input  logic [31:0]       tlbr_lo1,
   input  logic [31:0]       tlbr_mask,
   output logic [31:0]       status_o,
   output logic [31:0]       cause_o,
   output logic [31:0]       epc_o,
   output logic [31:0]       entryhi_o,
   output logic [31:0]       entrylo0_o,
   output logic [31:0]       entrylo1_o,
   output logic [31:0]       pagemask_o,
   output logic [IDX_W-1:0]  index_o,
   output logic [IDX_W-1:0]  random_o,
   output logic              int_pending
);

   localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

   logic             index_p_q, index_p_d;
   logic [IDX_W-1:0] index_q, index_d, random_q, random_d, wired_q, wired_d;
   logic [31:0]      entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
   logic [31:0]      pagemask_q, pagemask_d, entryhi_q, entryhi_d;
   logic [31:0]      badva_q, badva_d, status_q, status_d, epc_q, epc_d;
   logic [2:0]       k0_q, k0_d;
   logic             bd_q, bd_d;
   logic [4:0]       exc_code_q, exc_code_d;
   logic [1:0]       ip_sw_q, ip_sw_d;
   logic [HW_INT-1:0] ip_hw_q;

   logic [31:0] count, compare;
   logic        ti;
   logic        wr_count, wr_compare, wr_wired;
   logic [5:0]  hw_ext;
   logic [7:0]  ip;

   assign wr_count   = we && (waddr == CP0_COUNT);
   assign wr_compare = we && (waddr == CP0_COMPARE);
   assign wr_wired   = we && (waddr == CP0_WIRED);

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (wr_count),
      .compare_we (wr_compare),
      .wdata      (wdata),
      .count_o    (count),
      .compare_o  (compare),
      .ti_o       (ti)
   );

   // Unimplemented interrupt lines read as zero.
   for (genvar gi = 0; gi < 6; gi++) begin : g_hw
      if (gi < HW_INT) begin : g_on
         assign hw_ext[gi] = ip_hw_q[gi];
      end else begin : g_off
         assign hw_ext[gi] = 1'b0;
      end
   end

   assign ip = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};

   always_comb begin
      index_p_d  = index_p_q;
      index_d    = index_q;
      wired_d    = wired_q;
      entrylo0_d = entrylo0_q;
      entrylo1_d = entrylo1_q;
      pagemask_d = pagemask_q;
      entryhi_d  = entryhi_q;
      badva_d    = badva_q;
      status_d   = status_q;
      epc_d      = epc_q;
      k0_d       = k0_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      ip_sw_d    = ip_sw_q;

      if (we) begin
         case (waddr)
            CP0_INDEX:    index_d    = wdata[IDX_W-1:0];
            CP0_ENTRYLO0: entrylo0_d = wdata & ENTRYLO_WMASK;
            CP0_ENTRYLO1: entrylo1_d = wdata & ENTRYLO_WMASK;
            CP0_PAGEMASK: pagemask_d = wdata & PAGEMASK_WMASK;
            CP0_WIRED:    wired_d    = wdata[IDX_W-1:0];
            CP0_ENTRYHI:  entryhi_d  = wdata & ENTRYHI_WMASK;
            CP0_STATUS:   status_d   = wdata & STATUS_WMASK;
            CP0_CAUSE:    ip_sw_d    = wdata[CA_IP_LO+1:CA_IP_LO];
            CP0_EPC:      epc_d      = wdata;
            CP0_CONFIG:   k0_d       = wdata[2:0];
            default: ;
         endcase
      end

      if (wr_wired || (wired_q >= RAND_TOP) || (random_q == wired_q) || (random_q == '0))
         random_d = RAND_TOP;
      else
         random_d = random_q - 1'b1;

      // Pipeline-driven updates are applied after mtc0 so they take priority.
      if (tlbr_we) begin
         entryhi_d  = tlbr_hi & ENTRYHI_WMASK;
         entrylo0_d = tlbr_lo0 & ENTRYLO_WMASK;
         entrylo1_d = tlbr_lo1 & ENTRYLO_WMASK;
         pagemask_d = tlbr_mask & PAGEMASK_WMASK;
      end
      if (tlbp_we) begin
         index_p_d = ~tlbp_hit;
         index_d   = tlbp_idx;
      end
      if (eret) status_d[ST_EXL] = 1'b0;
      if (exc_valid) begin
         if (!status_q[ST_EXL]) begin
            epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
            bd_d  = exc_bd;
         end
         status_d[ST_EXL] = 1'b1;
         exc_code_d       = exc_code;
         if (exc_badva_we) begin
            badva_d         = exc_badva;
            entryhi_d[31:13] = exc_badva[31:13];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         index_p_q  <= 1'b0;
         index_q    <= '0;
         random_q   <= RAND_TOP;
         wired_q    <= '0;
         entrylo0_q <= '0;
         entrylo1_q <= '0;
         pagemask_q <= '0;
         entryhi_q  <= '0;
         badva_q    <= '0;
         status_q   <= STATUS_RESET;
         epc_q      <= '0;
         k0_q       <= K0_RESET;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
      end else begin
         index_p_q  <= index_p_d;
         index_q    <= index_d;
         random_q   <= random_d;
         wired_q    <= wired_d;
         entrylo0_q <= entrylo0_d;
         entrylo1_q <= entrylo1_d;
         pagemask_q <= pagemask_d;
         entryhi_q  <= entryhi_d;
         badva_q    <= badva_d;
         status_q   <= status_d;
         epc_q      <= epc_d;
         k0_q       <= k0_d;
         bd_q       <= bd_d;
         exc_code_q <= exc_code_d;
         ip_sw_q    <= ip_sw_d;
         ip_hw_q    <= hw_int;
      end
   end

   assign status_o    = status_q;
   assign cause_o     = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
   assign epc_o       = epc_q;
   assign entryhi_o   = entryhi_q;
   assign entrylo0_o  = entrylo0_q;
   assign entrylo1_o  = entrylo1_q;
   assign pagemask_o  = pagemask_q;
   assign index_o     = index_q;
   assign random_o    = random_q;
   assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL] & (|(ip & status_q[15:8]));

   always_comb begin
      rdata = '0;
      case (raddr)
         CP0_INDEX:    rdata = {index_p_q, {(31-IDX_W){1'b0}}, index_q};
         CP0_RANDOM:   rdata = 32'(random_q);
         CP0_ENTRYLO0: rdata = entrylo0_q;
         CP0_ENTRYLO1: rdata = entrylo1_q;
         CP0_PAGEMASK: rdata = pagemask_q;
         CP0_WIRED:    rdata = 32'(wired_q);
         CP0_BADVADDR: rdata = badva_q;
         CP0_COUNT:    rdata = count;
         CP0_ENTRYHI:  rdata = entryhi_q;
         CP0_COMPARE:  rdata = compare;
         CP0_STATUS:   rdata = status_q;
         CP0_CAUSE:    rdata = cause_o;
         CP0_EPC:      rdata = epc_q;
         CP0_CONFIG:   rdata = {1'b1, 28'b0, k0_q};
         default:      rdata = '0;
      endcase
   end

endmodule
